// File: rtl/rns16_byte_tx.sv
// rns16_byte_tx: word-to-byte serializer for the rns16 8-bit byte-stream link.
//
// A word arrives on a valid/ready port. It waits in a small word FIFO and then
// moves into a shift register (SR). The SR sends the word as BYTES bytes on a
// byte-wide valid/ready port. The byte order is LSB first unless MSB_FIRST=1.
// When the FIFO is empty and the SR is free, an incoming word skips the FIFO
// and loads straight into the SR. This gives latency 1 from in_fire to the
// first byte. Consecutive words are sent with no bubble between them.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_word    in   WORD_W-bit word to transmit
//   in_valid   in   in_word is valid
//   in_ready   out  a word can be accepted (registered)
//   out_byte   out  current byte
//   out_valid  out  out_byte is valid
//   out_ready  in   downstream accepts out_byte
//   out_last   out  out_byte is the final byte of its word
//   busy       out  FIFO non-empty or SR holds a word
module rns16_byte_tx #(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int MSB_FIRST  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int BYTES = WORD_W / 8;
  localparam int KW    = $clog2(BYTES);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [KW-1:0] K_LAST = KW'(BYTES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q,    state_d;
  logic [WORD_W-1:0]   sr_q,       sr_d;
  logic [KW-1:0]       k_q,        k_d;
  logic [PW-1:0]       wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]       count_q,    count_d;
  logic                in_ready_q, in_ready_d;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];

  logic    in_fire, out_fire, k_last, need_load, pop, bypass, push;
  logic [KW-1:0] byte_idx;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == SEND);
  assign k_last    = (k_q == K_LAST);
  assign out_last  = out_valid & k_last;
  assign busy      = (count_q != '0) | (state_q == SEND);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  // The SR is free this cycle if it is idle, or if its last byte is leaving now.
  assign need_load = (state_q == IDLE) | (out_fire & k_last);
  assign pop       = need_load & (count_q != '0);
  // An incoming word bypasses the FIFO only when nothing is queued ahead of it.
  assign bypass    = need_load & (count_q == '0) & in_fire;
  assign push      = in_fire & ~bypass;

  // Byte select: k counts the bytes sent. The SR byte it addresses depends on the byte order.
  assign byte_idx  = (MSB_FIRST != 0) ? (K_LAST - k_q) : k_q;
  assign out_byte  = sr_q[8*int'(byte_idx) +: 8];

  always_comb begin
    // NOTE: every _d starts from its _q so that no path through this block
    // leaves a variable unassigned; an unassigned path would infer a latch.
    state_d  = state_q;
    sr_d     = sr_q;
    k_d      = k_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (out_fire && !k_last) k_d = k_q + KW'(1);

    if (need_load) begin
      k_d = '0;
      if (pop) begin
        sr_d    = mem_q[rd_ptr_q];
        state_d = SEND;
      end else if (bypass) begin
        sr_d    = in_word;
        state_d = SEND;
      end else begin
        state_d = IDLE;
      end
    end

    if (push) wr_ptr_d = (wr_ptr_q == P_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == P_LAST) ? '0 : rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;  // idle, or push and pop together
    endcase

    in_ready_d = (count_d < C_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      k_q        <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      k_q        <= k_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // NOTE: FIFO storage has no reset. count_q and the pointers define which
  // entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_word;
  end

endmodule

// File: tb/tb_rns16_byte_tx.sv
// Directed self-checking bench for rns16_byte_tx.
// u_dut uses the default parameters (LSB first). u_msb uses MSB_FIRST=1.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at
// the same point. The DUT outputs are all registered, so they are stable there.
module tb_rns16_byte_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  logic [15:0] m_in_word;
  logic        m_in_valid;
  logic        m_in_ready;
  logic [7:0]  m_out_byte;
  logic        m_out_valid;
  logic        m_out_ready;
  logic        m_out_last;
  logic        m_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rns16_byte_tx u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  rns16_byte_tx #(.MSB_FIRST(1)) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (m_in_word),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .out_byte  (m_out_byte),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .out_last  (m_out_last),
    .busy      (m_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [15:0] b2b_words [3];
    logic [7:0]  b2b_bytes [6];
    logic [7:0]  bp_bytes  [6];
    logic [7:0]  held_byte;
    logic [7:0]  low_byte;
    int          accepted;
    int          next_w;
    int          rx_words;
    int          byte_i;
    int          cyc;
    bit          f_in;
    bit          f_out;
    bit          cur_last;
    logic [7:0]  cur_byte;

    b2b_words = '{16'h0001, 16'hFFFE, 16'hA55A};
    b2b_bytes = '{8'h01, 8'h00, 8'hFE, 8'hFF, 8'h5A, 8'hA5};
    bp_bytes  = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33};

    rst_n       = 1'b0;
    in_word     = 16'h5555;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    m_in_word   = 16'h0;
    m_in_valid  = 1'b0;
    m_out_ready = 1'b0;

    // Reset held for 4 cycles with in_valid high: nothing may be accepted.
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready",  32'(in_ready),  32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      check("rst_out_last",  32'(out_last),  32'h0);
      check("rst_out_byte",  32'(out_byte),  32'h0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    check("post_rst_idle",     32'(out_valid), 32'h0);

    // Single word 0x1234: bytes 34 then 12, latency 1, out_last on the second byte only.
    out_ready = 1'b1;
    in_word   = 16'h1234;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_v0",    32'(out_valid), 32'h1);
    check("single_b0",    32'(out_byte),  32'h34);
    check("single_last0", 32'(out_last),  32'h0);
    step();
    check("single_v1",    32'(out_valid), 32'h1);
    check("single_b1",    32'(out_byte),  32'h12);
    check("single_last1", 32'(out_last),  32'h1);
    step();
    check("single_done",  32'(out_valid), 32'h0);
    check("single_busy",  32'(busy),      32'h0);

    // Three words back to back: six bytes on consecutive cycles.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        in_word  = b2b_words[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check("b2b_valid", 32'(out_valid), 32'h1);
      check("b2b_byte",  32'(out_byte),  32'(b2b_bytes[i]));
      check("b2b_last",  32'(out_last),  32'(i % 2));
    end
    in_valid = 1'b0;
    step();
    check("b2b_done", 32'(out_valid), 32'h0);

    // Back-pressure: out_ready low for 10 cycles with a continuous word stream.
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    held_byte = 8'h00;
    for (int i = 0; i < 10; i++) begin
      in_word = 16'h1101 * 16'(accepted + 1);
      f_in    = in_ready;
      step();
      if (f_in) accepted++;
      if (i == 0) held_byte = out_byte;
    end
    in_valid = 1'b0;
    check("bp_accepted",  32'(accepted),  32'd3);
    check("bp_in_ready",  32'(in_ready),  32'h0);
    check("bp_first",     32'(held_byte), 32'h01);
    check("bp_stable",    32'(out_byte),  32'h01);
    check("bp_valid_hold", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_drain_valid", 32'(out_valid), 32'h1);
      check("bp_drain_byte",  32'(out_byte),  32'(bp_bytes[i]));
      step();
    end
    check("bp_drain_done", 32'(out_valid), 32'h0);
    check("bp_drain_busy", 32'(busy),      32'h0);

    // Reset mid-word: after 0xEF fires, reset; 0xBE must never fire.
    in_word  = 16'hBEEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_b0", 32'(out_byte), 32'hEF);
    step();
    check("mid_b1_shown", 32'(out_byte), 32'hBE);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_busy",  32'(busy),      32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    check("mid_idle_after", 32'(out_valid), 32'h0);
    in_word  = 16'h0102;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid_next_b0",   32'(out_byte), 32'h02);
    check("mid_next_v0",   32'(out_valid), 32'h1);
    step();
    check("mid_next_b1",   32'(out_byte), 32'h01);
    check("mid_next_last", 32'(out_last), 32'h1);
    step();
    check("mid_next_done", 32'(out_valid), 32'h0);

    // MSB_FIRST=1 instance: 0x1234 gives 12 then 34.
    m_in_word   = 16'h1234;
    m_in_valid  = 1'b1;
    m_out_ready = 1'b1;
    step();
    m_in_valid = 1'b0;
    check("msb_b0",    32'(m_out_byte),  32'h12);
    check("msb_last0", 32'(m_out_last),  32'h0);
    step();
    check("msb_b1",    32'(m_out_byte),  32'h34);
    check("msb_last1", 32'(m_out_last),  32'h1);
    step();
    check("msb_done",  32'(m_out_valid), 32'h0);

    // Sweep of 300 words with random gaps and random back-pressure. Words
    // 0..299 must come back in order, reassembled from byte pairs.
    next_w   = 0;
    rx_words = 0;
    byte_i   = 0;
    low_byte = 8'h00;
    cyc      = 0;
    while (rx_words < 300 && cyc < 20000) begin
      in_valid  = (next_w < 300) && ($urandom_range(0, 3) != 0);
      in_word   = 16'(next_w);
      out_ready = $urandom_range(0, 1) != 0;
      f_in      = in_valid & in_ready;
      f_out     = out_valid & out_ready;
      cur_byte  = out_byte;
      cur_last  = out_last;
      step();
      cyc++;
      if (f_in) next_w++;
      if (f_out) begin
        if (byte_i == 0) begin
          low_byte = cur_byte;
          byte_i   = 1;
          if (cur_last) check("sweep_last_lo", 32'(cur_last), 32'h0);
        end else begin
          check("sweep_word", 32'({cur_byte, low_byte}), 32'(rx_words));
          if (!cur_last) check("sweep_last_hi", 32'(cur_last), 32'h1);
          byte_i = 0;
          rx_words++;
        end
      end
    end
    in_valid = 1'b0;
    check("sweep_count", 32'(rx_words), 32'd300);
    check("sweep_partial", 32'(byte_i), 32'd0);
    step();
    check("sweep_idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
